// File: rtl/ysyx_24110015_mem_arbiter.sv
`default_nettype none
// ============================================================================
// ysyx_24110015_mem_arbiter
// Round-robin IFU/LSU arbiter onto one memory port, one outstanding access,
// response watchdog.
// Revision: 1.0
// ============================================================================
module ysyx_24110015_mem_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             r_state;
  logic               r_sel;         // 0 = IFU, 1 = LSU
  logic               r_last_grant;
  logic [31:0]        r_addr;
  logic               r_wen;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wmask;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_idle;
  logic               w_pick_lsu;
  logic               w_accept;
  logic               w_busy;
  logic               w_timeout;
  logic               w_sel_resp_ready;
  logic               w_rsp_valid;
  logic               w_rsp_err;
  logic [31:0]        w_rsp_data;

  assign w_idle     = (r_state == S_IDLE);
  // On a tie the master that lost last time wins.
  assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_grant);
  assign w_accept   = w_idle && (ifu_req_valid || lsu_req_valid);
  assign w_busy     = (r_state == S_REQ) || (r_state == S_RESP);
  assign w_timeout  = (TIMEOUT != 0) && w_busy && (r_cnt == c_cnt_last);

  assign ifu_req_ready = rst && w_idle && ifu_req_valid && !w_pick_lsu;
  assign lsu_req_ready = rst && w_idle && w_pick_lsu;

  assign w_sel_resp_ready = r_sel ? lsu_resp_ready : ifu_resp_ready;

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_wen       = r_wen;
  assign mem_wmask     = r_wmask;

  always_comb begin
    mem_resp_ready = 1'b0;
    w_rsp_valid    = 1'b0;
    w_rsp_err      = 1'b0;
    w_rsp_data     = 32'd0;
    case (r_state)
      S_IDLE: mem_resp_ready = 1'b1;
      S_RESP: begin
        mem_resp_ready = w_sel_resp_ready;
        w_rsp_valid    = mem_resp_valid;
        w_rsp_err      = mem_resp_err;
        w_rsp_data     = mem_rdata;
      end
      S_ERR: begin
        mem_resp_ready = 1'b1;
        w_rsp_valid    = 1'b1;
        w_rsp_err      = 1'b1;
      end
      default: mem_resp_ready = 1'b0;
    endcase
  end

  assign ifu_resp_valid = !r_sel && w_rsp_valid;
  assign ifu_resp_err   = !r_sel && w_rsp_err;
  assign ifu_rdata      = r_sel ? 32'd0 : w_rsp_data;
  assign lsu_resp_valid = r_sel && w_rsp_valid;
  assign lsu_resp_err   = r_sel && w_rsp_err;
  assign lsu_rdata      = (r_sel && !r_wen) ? w_rsp_data : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b0;
      r_addr       <= 32'd0;
      r_wen        <= 1'b0;
      r_wdata      <= 32'd0;
      r_wmask      <= 4'd0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sel        <= w_pick_lsu;
            r_last_grant <= w_pick_lsu;
            r_cnt        <= '0;
            r_state      <= S_REQ;
            if (w_pick_lsu) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= 32'd0;
              r_wmask <= 4'd0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout)
            r_state <= S_ERR;
          else if (mem_req_ready)
            r_state <= S_RESP;
        end
        S_RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout)
            r_state <= S_ERR;
          else if (mem_resp_valid && w_sel_resp_ready)
            r_state <= S_IDLE;
        end
        S_ERR: begin
          if (w_sel_resp_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ysyx_24110015_mem_arbiter
// Directed self-checking bench for the IFU/LSU memory arbiter (TIMEOUT = 8).
// Revision: 1.0
// ============================================================================
module tb_ysyx_24110015_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_24110015_mem_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tie-break round with both masters requesting; the slave answers at once.
  task automatic serve(input logic exp_lsu);
    #1;
    chk1("tie_lsu_ready", lsu_req_ready, exp_lsu);
    chk1("tie_ifu_ready", ifu_req_ready, !exp_lsu);
    tick();
    mem_req_ready = 1'b1;
    #1;
    chk32("tie_mem_addr", mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0100);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_0000;
    #1;
    chk1("tie_lsu_resp", lsu_resp_valid, exp_lsu);
    chk1("tie_ifu_resp", ifu_resp_valid, !exp_lsu);
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;

    // Reset values
    #3;
    chk1("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_mem_resp_ready", mem_resp_ready, 1'b1);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    #9;
    rst = 1'b1;
    tick();

    // Single IFU read with an immediately ready slave
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    chk1("ifu_req_ready", ifu_req_ready, 1'b1);
    chk1("lsu_req_ready_idle", lsu_req_ready, 1'b0);
    tick();
    ifu_req_valid = 0; ifu_addr = 32'h1234_5678;
    mem_req_ready = 1;
    #1;
    chk1("ifu_mem_req_valid", mem_req_valid, 1'b1);
    chk32("ifu_mem_addr", mem_addr, 32'h8000_0000);
    chk1("ifu_mem_wen", mem_wen, 1'b0);
    chk32("ifu_mem_wmask", {28'd0, mem_wmask}, 32'h0);
    chk1("ifu_req_ready_busy", ifu_req_ready, 1'b0);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    #1;
    chk1("ifu_resp_valid", ifu_resp_valid, 1'b1);
    chk32("ifu_rdata", ifu_rdata, 32'h0010_0073);
    chk1("ifu_resp_err", ifu_resp_err, 1'b0);
    chk1("ifu_lsu_resp_valid", lsu_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 0;
    #1;
    chk1("ifu_done_req_valid", mem_req_valid, 1'b0);
    chk1("ifu_done_resp_valid", ifu_resp_valid, 1'b0);
    ifu_req_valid = 1;
    #1;
    chk1("ifu_cycle3_ready", ifu_req_ready, 1'b1);
    ifu_req_valid = 0;

    // LSU write held across five cycles of slave backpressure
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    #1;
    chk1("wr_lsu_req_ready", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("wr_mem_req_valid", mem_req_valid, 1'b1);
      chk32("wr_mem_addr", mem_addr, 32'h8000_1000);
      chk32("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1("wr_mem_wen", mem_wen, 1'b1);
      chk32("wr_mem_wmask", {28'd0, mem_wmask}, 32'h3);
      chk1("wr_mem_resp_ready", mem_resp_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk1("wr_lsu_resp_valid", lsu_resp_valid, 1'b1);
    chk32("wr_lsu_rdata", lsu_rdata, 32'h0);
    chk1("wr_lsu_resp_err", lsu_resp_err, 1'b0);
    tick();
    mem_resp_valid = 0;
    #1;
    chk1("wr_lsu_resp_once", lsu_resp_valid, 1'b0);

    // LSU read with master backpressure in RESP
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0;
    tick();
    lsu_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hA5A5_A5A5;
    lsu_resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("bp_mem_resp_ready", mem_resp_ready, 1'b0);
      chk1("bp_lsu_resp_valid", lsu_resp_valid, 1'b1);
      chk32("bp_lsu_rdata", lsu_rdata, 32'hA5A5_A5A5);
      tick();
    end
    lsu_resp_ready = 1;
    #1;
    chk1("bp_mem_resp_ready_go", mem_resp_ready, 1'b1);
    tick();
    mem_resp_valid = 0;
    #1;
    chk1("bp_done", lsu_resp_valid, 1'b0);

    // Watchdog: slave never answers, error after 8 cycles in REQ
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 0;
    tick();
    lsu_req_valid = 0;
    lsu_resp_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1("to_mem_req_valid", mem_req_valid, 1'b1);
      chk1("to_no_resp", lsu_resp_valid, 1'b0);
      tick();
    end
    chk1("to_req_dropped", mem_req_valid, 1'b0);
    chk1("to_lsu_resp_valid", lsu_resp_valid, 1'b1);
    chk1("to_lsu_resp_err", lsu_resp_err, 1'b1);
    chk32("to_lsu_rdata", lsu_rdata, 32'h0);
    chk1("to_mem_resp_ready", mem_resp_ready, 1'b1);
    tick();
    chk1("to_err_held", lsu_resp_valid, 1'b1);
    lsu_resp_ready = 1;
    tick();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0BAD;
    #1;
    chk1("late_mem_resp_ready", mem_resp_ready, 1'b1);
    chk1("late_lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk1("late_ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk32("late_lsu_rdata", lsu_rdata, 32'h0);
    tick();
    mem_resp_valid = 0;

    // Asynchronous reset while in RESP
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    tick();
    ifu_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; ifu_resp_ready = 0;
    #1;
    chk1("ar_pre_resp_valid", ifu_resp_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("ar_ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk32("ar_ifu_rdata", ifu_rdata, 32'h0);
    chk1("ar_mem_resp_ready", mem_resp_ready, 1'b1);
    chk32("ar_mem_addr", mem_addr, 32'h0);
    mem_resp_valid = 0; ifu_resp_ready = 1;
    #3;
    rst = 1'b1;

    // Both masters requesting continuously: LSU, IFU, LSU, IFU
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    serve(1'b1);
    serve(1'b0);
    serve(1'b1);
    serve(1'b0);
    ifu_req_valid = 0; lsu_req_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24110015_mem_arbiter.md
# ysyx_24110015_mem_arbiter

Two-master, one-slave memory arbiter for the NPC core: shares the single data-memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It sits between IFU/LSU and the memory-side slave (SRAM model or bus bridge). It uses valid/ready handshakes on separate request and response channels, with one outstanding transaction. Round-robin arbitration and a response watchdog return an error to the requester if the slave stalls.

## Interface
Parameters:
- TIMEOUT, 1000 — max cycles a transaction may spend in REQ+RESP before an error response is forced; 0 disables the watchdog.
- CNT_W, 16 — watchdog counter width; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  32  IFU fetch address (read only)
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  32  fetched word
- ifu_resp_err  out  1  response is an error (timeout or slave error)
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  32  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte-enable mask
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_rdata  out  32  read data (0 for writes)
- lsu_resp_err  out  1  error flag
- mem_req_valid / mem_req_ready  out / in  1  slave request handshake
- mem_addr, mem_wdata  out  32  registered request address / data
- mem_wen  out  1  registered write flag (always 0 for IFU)
- mem_wmask  out  4  registered mask (4'b0000 for IFU)
- mem_resp_valid / mem_resp_ready  in / out  1  slave response handshake
- mem_rdata  in  32  slave read data
- mem_resp_err  in  1  slave error

## Operation
- FSM states: IDLE, REQ, RESP, ERR. Registers: state, sel (0 = IFU, 1 = LSU), last_grant, request latch (addr/wen/wdata/wmask), watchdog counter.
- IDLE: the winner's req_ready = 1 combinationally. The loser's req_ready = 0. On the accept edge, the arbiter latches the request, sets sel and last_grant, clears the counter, and moves to REQ.
- Arbitration: if only one valid, it wins. If both are valid, the master that did not win the previous grant wins. last_grant resets to IFU, so the LSU wins the first tie.
- REQ: mem_req_valid = 1 and mem_* are driven from the latch, held stable. On mem_req_valid && mem_req_ready, the FSM moves to RESP.
- RESP: mem_resp_ready = selected master's resp_ready. The selected master's resp_valid, rdata and resp_err are mem_resp_valid, mem_rdata and mem_resp_err, passed through combinationally. On a full handshake, the FSM moves to IDLE.
- Watchdog: the counter increments on every cycle spent in REQ or RESP. When it equals TIMEOUT (TIMEOUT ≠ 0), the FSM moves to ERR regardless of slave activity that cycle. mem_req_valid drops immediately, even if mem_req_ready is not yet seen.
- ERR: selected master sees resp_valid = 1, rdata = 0, resp_err = 1 until resp_ready, then the FSM moves to IDLE.
- In IDLE and ERR, mem_resp_ready = 1 so that stale late slave responses are drained. These responses are discarded and never forwarded.
- Non-selected master: resp_valid = 0, rdata = 0, resp_err = 0. Outside IDLE, both req_ready = 0.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, sel = 0, last_grant = IFU, counter = 0, latch = 0. All outputs are 0 except mem_resp_ready = 1 (IDLE). Reset mid-transaction aborts it with no response to the master.
- Minimum latency: accept in cycle 0, mem_req_valid in cycle 1. With mem_req_ready = 1 in cycle 1 and mem_resp_valid in cycle 2, the master response handshake occurs in cycle 2 and the next accept is possible in cycle 3.
- Exactly one outstanding transaction. No request is accepted while in REQ, RESP or ERR.
- Watchdog: ERR is entered on the edge where the counter reaches TIMEOUT, i.e. TIMEOUT cycles after entering REQ. With TIMEOUT = 0, the block never times out.
- Master inputs are sampled only on the accept edge and may change afterwards.

## Test plan
- Single IFU read, addr 0x80000000: slave ready immediately, mem_rdata 0x00100073 next cycle -> ifu_rdata 0x00100073, err 0, mem_wen 0, mem_wmask 0000, 3-cycle turnaround.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0011 -> mem_* match exactly while mem_req_valid is held across 5 cycles of mem_req_ready = 0; lsu_resp_valid is asserted once.
- IFU and LSU valid continuously from reset -> grants alternate LSU, IFU, LSU, IFU; no master is granted twice in a row.
- TIMEOUT = 8, slave never raises mem_resp_valid -> 8 cycles after REQ entry, the LSU gets resp_valid, resp_err = 1, rdata 0. A late mem_resp_valid in IDLE is consumed and not forwarded.
- Master backpressure: lsu_resp_ready = 0 for 4 cycles in RESP -> mem_resp_ready = 0 for those cycles and the response is held until ready.
- rst pulled low while in RESP -> all outputs reset asynchronously (before the next edge). After release, the next tie is granted to the LSU.
